// File: rtl/shader_isa_pkg.sv
// Shader ISA package: instruction field layout, op codes, loader FSM states
// and the instruction word encoder shared with the decoder side.
// Optional feature macro: SHADER_ENC_PARITY_EN (bit 0 carries even parity
// over the field bits [31:17]).
package shader_isa_pkg;

  localparam int INSTR_W  = 32;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int MASK_MSB = 29;
  localparam int MASK_LSB = 26;
  localparam int DEST_MSB = 25;
  localparam int DEST_LSB = 23;
  localparam int SRCA_MSB = 22;
  localparam int SRCA_LSB = 20;
  localparam int SRCB_MSB = 19;
  localparam int SRCB_LSB = 17;
  localparam int PAR_BIT  = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

  // Packs decoded fields into one instruction word; an all-zero word is a NOP.
  function automatic logic [INSTR_W-1:0] encode_instr(
    input logic [1:0] op,
    input logic [3:0] mask,
    input logic [2:0] dest,
    input logic [2:0] src_a,
    input logic [2:0] src_b
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]     = op;
    w[MASK_MSB:MASK_LSB] = mask;
    w[DEST_MSB:DEST_LSB] = dest;
    w[SRCA_MSB:SRCA_LSB] = src_a;
    w[SRCB_MSB:SRCB_LSB] = src_b;
`ifdef SHADER_ENC_PARITY_EN
    w[PAR_BIT] = ^w[OP_MSB:SRCB_LSB];
`else
    w[PAR_BIT] = 1'b0;
`endif
    return w;
  endfunction

endpackage

// File: rtl/shader_program_encoder_if.sv
// Field-input handshake and instruction-memory write port of the shader
// program encoder. The slave modport is the encoder's view, the master
// modport is the loader/memory side.
interface shader_program_encoder_if #(
  parameter int ADDR_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [3:0]        in_mask;
  logic [2:0]        in_dest;
  logic [2:0]        in_srcA;
  logic [2:0]        in_srcB;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              mem_wr_ready;

  modport slave (
    input  in_valid, in_op, in_mask, in_dest, in_srcA, in_srcB, mem_wr_ready,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output in_valid, in_op, in_mask, in_dest, in_srcA, in_srcB, mem_wr_ready,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

endinterface

// File: rtl/shader_enc_fifo.sv
// Synchronous FIFO buffering encoded instruction words between the field
// input and the memory write stage. DEPTH must be a power of two (>= 2).
// A push into a full FIFO is accepted when a pop happens on the same edge.
module shader_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = storage[rd_ptr];

  // Storage array; the occupancy count guards every read, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= wr_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/shader_program_encoder.sv
// Shader program encoder: accepts decoded instruction fields, packs them into
// 32-bit words, buffers them and writes them to the instruction memory at
// consecutive (wrapping) addresses for a session of 1..2**ADDR_W words.
// Optional feature macro: SHADER_ENC_PARITY_EN (even-parity bit 0 in every
// encoded word; handled inside shader_isa_pkg::encode_instr).
module shader_program_encoder
  import shader_isa_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          count,
  shader_program_encoder_if.slave  bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(2 ** ADDR_W);

  enc_state_t        state;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   accepted;
  logic [ADDR_W:0]   written;
  logic [ADDR_W:0]   accepted_inc;
  logic [ADDR_W:0]   written_inc;
  logic [ADDR_W-1:0] addr_ptr;

  logic              count_legal;
  logic              idle_like;
  logic              session_start;
  logic              push;
  logic              wr_fire;
  logic              stage_load;

  logic [31:0]       enc_word;
  logic [31:0]       fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  assign count_legal   = (count != '0) && (count <= MAX_COUNT);
  assign idle_like     = (state == IDLE) || (state == DONE);
  assign session_start = idle_like && start && count_legal;
  assign accepted_inc  = accepted + 1'b1;
  assign written_inc   = written + 1'b1;

  assign bus.in_ready  = (state == LOAD) && !fifo_full && (accepted < cnt_q);
  assign push          = bus.in_valid && bus.in_ready;
  assign wr_fire       = wr_en_q && bus.mem_wr_ready;
  assign stage_load    = !fifo_empty && (!wr_en_q || bus.mem_wr_ready);

  assign enc_word = encode_instr(bus.in_op, bus.in_mask, bus.in_dest,
                                 bus.in_srcA, bus.in_srcB);

  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;

  shader_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (enc_word),
    .pop     (stage_load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Session FSM: tracks accepted/written counts and drives busy/done/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_q    <= '0;
      accepted <= '0;
      written  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            if (count_legal) begin
              state    <= LOAD;
              cnt_q    <= count;
              accepted <= '0;
              written  <= '0;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (start) begin
            err <= 1'b1;
          end
          if (wr_fire) begin
            written <= written_inc;
          end
          if (push) begin
            accepted <= accepted_inc;
            if (accepted_inc == cnt_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (start) begin
            err <= 1'b1;
          end
          if (wr_fire) begin
            written <= written_inc;
            if (written_inc == cnt_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered write stage: holds a word until memory accepts it, restaging
  // from the FIFO on the same edge so writes can stream one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      addr_ptr  <= '0;
    end else begin
      if (session_start) begin
        addr_ptr <= base_addr;
      end else if (stage_load) begin
        addr_ptr <= addr_ptr + 1'b1;
      end
      if (stage_load) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_ptr;
        wr_data_q <= fifo_rd_data;
      end else if (wr_fire) begin
        wr_en_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shader_program_encoder.sv
// Self-checking bench for shader_program_encoder. Expected {addr, word}
// pairs are queued as tuples are issued; a negedge monitor pops and compares
// them on every accepted memory write and checks that a stalled write holds.
module tb_shader_program_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic        err;

  shader_program_encoder_if #(.ADDR_W(4)) bus ();

  shader_program_encoder #(
    .ADDR_W     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

`ifdef SHADER_ENC_PARITY_EN
  localparam logic [31:0] T2_WORD = 32'h1C14_0001;
`else
  localparam logic [31:0] T2_WORD = 32'h1C14_0000;
`endif

  int pass_cnt   = 0;
  int total_cnt  = 0;
  int cycle      = 0;
  int wr_cnt     = 0;
  int err_cnt    = 0;
  int done_cycle = 0;
  int tuples_acc = 0;
  int wr_cycles[$];
  logic [35:0] exp_q[$];

  logic        hold_pending = 1'b0;
  logic [3:0]  hold_addr;
  logic [31:0] hold_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Independent reference packing of the instruction fields.
  function automatic logic [31:0] model_word(input logic [1:0] op, input logic [3:0] m,
                                             input logic [2:0] d, input logic [2:0] a,
                                             input logic [2:0] b);
    logic [14:0] f;
    f = {op, m, d, a, b};
`ifdef SHADER_ENC_PARITY_EN
    return {f, 16'h0000, ^f};
`else
    return {f, 17'h00000};
`endif
  endfunction

  // Monitor: scoreboard compare on accepted writes, hold check on stalls.
  always @(negedge clk) begin
    logic [35:0] e;
    cycle++;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (done) done_cycle = cycle;
      if (err) err_cnt++;
      if (hold_pending) begin
        checkOutput("hold_en", bus.mem_wr_en, 1);
        checkOutput("hold_addr", bus.mem_wr_addr, hold_addr);
        checkOutput("hold_data", bus.mem_wr_data, hold_data);
      end
      hold_pending = bus.mem_wr_en && !bus.mem_wr_ready;
      hold_addr    = bus.mem_wr_addr;
      hold_data    = bus.mem_wr_data;
      if (bus.mem_wr_en && bus.mem_wr_ready) begin
        wr_cnt++;
        wr_cycles.push_back(cycle);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                   bus.mem_wr_addr, bus.mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write_addr_data", {bus.mem_wr_addr, bus.mem_wr_data}, e);
        end
      end
    end
  end

  // Issue one tuple and wait (bounded) for its handshake.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] m,
                               input logic [2:0] d, input logic [2:0] a,
                               input logic [2:0] b, input logic [31:0] exp_word,
                               input logic [3:0] exp_addr);
    int waitc = 0;
    exp_q.push_back({exp_addr, exp_word});
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_mask  = m;
    bus.in_dest  = d;
    bus.in_srcA  = a;
    bus.in_srcB  = b;
    do begin
      @(negedge clk);
      waitc++;
    end while (!bus.in_ready && waitc < 200);
    if (!bus.in_ready) begin
      total_cnt++;
      $display("[TB] FAIL in_handshake_timeout: in_ready stayed %0b, required 1", bus.in_ready);
      void'(exp_q.pop_back());
    end else begin
      tuples_acc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic startSession(input logic [3:0] b, input logic [4:0] c);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    checkOutput({name, "_done"}, done, 1);
    checkOutput({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    checkOutput({name, "_done_single_pulse"}, done, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    int e0;
    rst_n            = 1'b0;
    start            = 1'b0;
    base_addr        = '0;
    count            = '0;
    bus.in_valid     = 1'b0;
    bus.in_op        = '0;
    bus.in_mask      = '0;
    bus.in_dest      = '0;
    bus.in_srcA      = '0;
    bus.in_srcB      = '0;
    bus.mem_wr_ready = 1'b1;

    #12;
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_mem_wr_en", bus.mem_wr_en, 0);
    checkOutput("rst_mem_wr_addr", bus.mem_wr_addr, 0);
    checkOutput("rst_mem_wr_data", bus.mem_wr_data, 0);
    checkOutput("rst_busy_done_err", {busy, done, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: two-word program at base 0");
    startSession(4'd0, 5'd2);
    checkOutput("t1_busy", busy, 1);
    applyStimulus(2'b00, 4'hF, 3'd0, 3'd1, 3'd2, 32'h3C14_0000, 4'd0);
    applyStimulus(2'b01, 4'hF, 3'd1, 3'd0, 3'd3, 32'h7C86_0000, 4'd1);
    waitDone("t1");

    $display("[TB] test 2: encoding with partial mask and write latency");
    startSession(4'd5, 5'd1);
    applyStimulus(2'b00, 4'b0111, 3'd0, 3'd1, 3'd2, T2_WORD, 4'd5);
    @(negedge clk);
    checkOutput("t2_latency_not_early", bus.mem_wr_en, 0);
    @(negedge clk);
    checkOutput("t2_latency_en", bus.mem_wr_en, 1);
    waitDone("t2");

    $display("[TB] test 3: address wrap-around, streaming writes");
    w0 = wr_cycles.size();
    startSession(4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i), 4'(i * 3 + 1), 3'(i), 3'(7 - i), 3'(i + 2),
                    model_word(2'(i), 4'(i * 3 + 1), 3'(i), 3'(7 - i), 3'(i + 2)),
                    4'(14 + i));
    end
    waitDone("t3");
    checkOutput("t3_write_count", wr_cycles.size() - w0, 4);
    if (wr_cycles.size() - w0 == 4) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("t3_consecutive", wr_cycles[w0 + k + 1] - wr_cycles[w0 + k], 1);
      end
      checkOutput("t3_done_latency", done_cycle - wr_cycles[wr_cycles.size() - 1], 1);
    end

    $display("[TB] test 4: memory backpressure");
    bus.mem_wr_ready = 1'b0;
    w0 = wr_cnt;
    tuples_acc = 0;
    startSession(4'd8, 5'd8);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(2'(3 - (i % 4)), 4'(15 - i), 3'(i), 3'(i + 1), 3'(6 - i),
                        model_word(2'(3 - (i % 4)), 4'(15 - i), 3'(i), 3'(i + 1), 3'(6 - i)),
                        4'(8 + i));
        end
      end
      begin
        repeat (10) @(negedge clk);
        checkOutput("t4_in_ready_low", bus.in_ready, 0);
        checkOutput("t4_accepted_when_full", tuples_acc, 5);
        checkOutput("t4_no_write_while_stalled", wr_cnt - w0, 0);
        checkOutput("t4_stalled_addr", bus.mem_wr_addr, 8);
        @(posedge clk);
        #1;
        bus.mem_wr_ready = 1'b1;
      end
    join
    waitDone("t4");
    checkOutput("t4_write_count", wr_cnt - w0, 8);

    $display("[TB] test 5: illegal starts");
    w0 = wr_cnt;
    e0 = err_cnt;
    startSession(4'd0, 5'd0);
    @(negedge clk);
    checkOutput("t5_err_count0", err, 1);
    checkOutput("t5_busy_count0", busy, 0);
    @(posedge clk);
    #1;
    startSession(4'd0, 5'd17);
    @(negedge clk);
    checkOutput("t5_err_count17", err, 1);
    checkOutput("t5_busy_count17", busy, 0);
    @(posedge clk);
    #1;
    startSession(4'd9, 5'd1);
    startSession(4'd2, 5'd3);
    @(negedge clk);
    checkOutput("t5_err_while_busy", err, 1);
    checkOutput("t5_busy_kept", busy, 1);
    @(posedge clk);
    #1;
    checkOutput("t5_err_pulse_count", err_cnt - e0, 3);
    checkOutput("t5_no_write", wr_cnt - w0, 0);
    applyStimulus(2'b11, 4'b1010, 3'd7, 3'd5, 3'd4,
                  model_word(2'b11, 4'b1010, 3'd7, 3'd5, 3'd4), 4'd9);
    waitDone("t5");

    $display("[TB] test 6: reset mid-session");
    w0 = wr_cnt;
    startSession(4'd0, 5'd6);
    applyStimulus(2'b10, 4'b1100, 3'd3, 3'd2, 3'd1,
                  model_word(2'b10, 4'b1100, 3'd3, 3'd2, 3'd1), 4'd0);
    applyStimulus(2'b01, 4'b0011, 3'd4, 3'd6, 3'd7,
                  model_word(2'b01, 4'b0011, 3'd4, 3'd6, 3'd7), 4'd1);
    for (int n = 0; n < 50 && (wr_cnt - w0) < 2; n++) @(negedge clk);
    checkOutput("t6_two_writes", wr_cnt - w0, 2);
    checkOutput("t6_busy_before_reset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy_done_err", {busy, done, err}, 0);
    checkOutput("t6_rst_in_ready", bus.in_ready, 0);
    checkOutput("t6_rst_mem_wr_en", bus.mem_wr_en, 0);
    checkOutput("t6_rst_mem_wr_addr", bus.mem_wr_addr, 0);
    checkOutput("t6_rst_mem_wr_data", bus.mem_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    startSession(4'd3, 5'd1);
    applyStimulus(2'b00, 4'b0001, 3'd2, 3'd3, 3'd4,
                  model_word(2'b00, 4'b0001, 3'd2, 3'd3, 3'd4), 4'd3);
    waitDone("t6");

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
